pong_game_ctrl: RTL
===================

# pong_game_ctrl

Match sequencer for the Pong design. It runs from the 100 MHz system clock and sits between the debounced player buttons, the ball block's score pulses and the frame timing from the VGA controller. It steps the game through idle, serve, rally, point-freeze, pause and game-over, and drives the enables and strobes that let the ball, paddles and score blocks run. It also keeps its own per-player point totals, which it uses to detect the winning score.

## Interface
Parameters:
- WIN_SCORE, 11: points needed to win; legal range 1–99.
- SERVE_FRAMES, 60: frames the ball is held centred before each serve.
- POINT_FRAMES, 90: frames the field is frozen after a point.

Ports:
- clk  in  1  100 MHz system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- start_btn  in  1  debounced level; the block acts on its rising edge.
- pause_btn  in  1  debounced level; the block acts on its rising edge.
- score1  in  1  one-cycle pulse from the ball block: player 1 scored.
- score2  in  1  one-cycle pulse from the ball block: player 2 scored.
- ball_run  out  1  level; ball position may advance.
- ball_center  out  1  level; ball held at screen centre.
- serve_dir  out  1  0 = serve toward player 2 (right), 1 = toward player 1 (left).
- paddle_en  out  1  level; paddle movement allowed.
- score_clr  out  1  one-cycle pulse; the score block clears its totals.
- game_over  out  1  level; high in OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- p1_pts, p2_pts  out  7 each  point totals.
- state  out  3  encoded state, for debug.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5. Codes 6 and 7 go to IDLE on the next cycle.
- Start and pause edges: registered previous samples; edge = level & ~prev.
- IDLE
  - Outputs: ball_center=1, paddle_en=0.
  - On a start edge: pulse score_clr, clear the point totals, serve_dir=0, frame_cnt=0, go to SERVE.
- SERVE
  - Outputs: ball_center=1, paddle_en=1.
  - frame_cnt increments on each frame_tick.
  - When frame_cnt = SERVE_FRAMES−1 and frame_tick=1: go to PLAY.
- PLAY
  - Outputs: ball_run=1, paddle_en=1.
  - On score1: p1_pts+1, serve_dir=0 (next serve goes to the player who conceded), frame_cnt=0.
    - If the new p1_pts = WIN_SCORE: go to OVER with winner=01.
    - Otherwise go to POINT.
  - score2 is symmetric: serve_dir=1, winner=10.
  - On a pause edge with no score pulse in the same cycle: go to PAUSE.
- POINT
  - Outputs: all movement off (ball_run=0, paddle_en=0).
  - Counts POINT_FRAMES frames, then sets frame_cnt=0 and goes to SERVE.
- PAUSE
  - Outputs: all movement off; frame_cnt holds.
  - On a pause edge: go to PLAY.
  - Start edges are ignored.
- OVER
  - Outputs: game_over=1, all movement off, winner held.
  - On a start edge: behave exactly as a start edge in IDLE (clear, winner=00, go to SERVE).
- Simultaneous score1 and score2 in PLAY: only player 1 is credited; score2 is dropped.
- Score has priority over pause in the same cycle; that pause edge is consumed.
- Score pulses are ignored outside PLAY.
- Point totals saturate at WIN_SCORE and never wrap.
- frame_cnt is 8 bits wide; SERVE_FRAMES and POINT_FRAMES must each be ≤ 256.

## Timing
- All outputs are registered: an input event shows on the outputs on the next rising clk edge, giving 1-cycle latency.
- score_clr is high for exactly one cycle, the cycle after the start edge is sampled.
- Reset values: state=IDLE, ball_center=1, every other output 0, frame_cnt=0, previous button samples=0.
- A button already held through reset does not produce an edge.
- Reset asserted mid-game returns to IDLE asynchronously. After release, the first edge can be recognised no earlier than the second clock edge.
- SERVE lasts exactly SERVE_FRAMES frame_ticks. PLAY is entered the cycle after the final tick.

## Test plan
- Reset, then start edge → score_clr high 1 cycle; state=SERVE. After 60 frame_ticks, state=PLAY and ball_run=1.
- In PLAY, score2 pulse → p2_pts=1, serve_dir=1, state=POINT. After 90 ticks state=SERVE; after 60 more state=PLAY.
- With WIN_SCORE=3, three score1 pulses separated by full serve cycles → state=OVER, winner=01, game_over=1, p1_pts=3. A further score1 leaves p1_pts=3.
- score1 and score2 in the same cycle → p1_pts+1 only, p2_pts unchanged.
- Pause edge in PLAY → PAUSE, ball_run=0. Score pulses are ignored and frame_ticks leave frame_cnt unchanged. Second pause edge → PLAY.
- Drive reset low while in POINT → state=IDLE immediately with reset output values. start_btn held high across release → no transition until it is released and pressed again.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: steps idle/serve/rally/point/pause/over, gates ball and
// paddle motion, and keeps per-player point totals to detect the winner.
module pong_game_ctrl #(
   parameter int unsigned WIN_SCORE    = 11,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned POINT_FRAMES = 90
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic       score1,
   input  logic       score2,
   output logic       ball_run,
   output logic       ball_center,
   output logic       serve_dir,
   output logic       paddle_en,
   output logic       score_clr,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [6:0] p1_pts,
   output logic [6:0] p2_pts,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      PAUSE = 3'd4,
      OVER  = 3'd5
   } state_e;

   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
   localparam logic [6:0] WIN_PTS    = 7'(WIN_SCORE);

   state_e     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [6:0] p1_q, p1_d, p2_q, p2_d;
   logic [6:0] p1_inc, p2_inc;
   logic [1:0] winner_q, winner_d;
   logic       serve_dir_q, serve_dir_d;
   logic       score_clr_q, score_clr_d;
   logic       ball_run_q, ball_run_d;
   logic       ball_center_q, ball_center_d;
   logic       paddle_en_q, paddle_en_d;
   logic       game_over_q, game_over_d;
   logic       start_prev_q, pause_prev_q;
   logic       armed_q;
   logic       start_edge, pause_edge;

   // armed_q blocks edge detection on the first clock after reset so a button
   // held through reset is absorbed into the previous-sample flops.
   always_comb begin
      start_edge = armed_q & start_btn & ~start_prev_q;
      pause_edge = armed_q & pause_btn & ~pause_prev_q;
      p1_inc     = (p1_q < WIN_PTS) ? p1_q + 7'd1 : p1_q;
      p2_inc     = (p2_q < WIN_PTS) ? p2_q + 7'd1 : p2_q;

      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      winner_d    = winner_q;
      serve_dir_d = serve_dir_q;
      score_clr_d = 1'b0;

      case (state_q)
         IDLE, OVER: begin
            if (start_edge) begin
               score_clr_d = 1'b1;
               p1_d        = '0;
               p2_d        = '0;
               winner_d    = '0;
               serve_dir_d = 1'b0;
               frame_cnt_d = '0;
               state_d     = SERVE;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (frame_cnt_q == SERVE_LAST) begin
                  frame_cnt_d = '0;
                  state_d     = PLAY;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
         PLAY: begin
            // Player 1 wins a simultaneous score; a score also swallows any pause edge.
            if (score1) begin
               p1_d        = p1_inc;
               serve_dir_d = 1'b0;
               frame_cnt_d = '0;
               if (p1_inc == WIN_PTS) begin
                  winner_d = 2'b01;
                  state_d  = OVER;
               end else begin
                  state_d  = POINT;
               end
            end else if (score2) begin
               p2_d        = p2_inc;
               serve_dir_d = 1'b1;
               frame_cnt_d = '0;
               if (p2_inc == WIN_PTS) begin
                  winner_d = 2'b10;
                  state_d  = OVER;
               end else begin
                  state_d  = POINT;
               end
            end else if (pause_edge) begin
               state_d = PAUSE;
            end
         end
         POINT: begin
            if (frame_tick) begin
               if (frame_cnt_q == POINT_LAST) begin
                  frame_cnt_d = '0;
                  state_d     = SERVE;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
         PAUSE: begin
            if (pause_edge) state_d = PLAY;
         end
         default: state_d = IDLE;
      endcase

      ball_run_d    = (state_d == PLAY);
      ball_center_d = (state_d == IDLE) || (state_d == SERVE);
      paddle_en_d   = (state_d == SERVE) || (state_d == PLAY);
      game_over_d   = (state_d == OVER);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         frame_cnt_q   <= '0;
         p1_q          <= '0;
         p2_q          <= '0;
         winner_q      <= '0;
         serve_dir_q   <= 1'b0;
         score_clr_q   <= 1'b0;
         ball_run_q    <= 1'b0;
         ball_center_q <= 1'b1;
         paddle_en_q   <= 1'b0;
         game_over_q   <= 1'b0;
         start_prev_q  <= 1'b0;
         pause_prev_q  <= 1'b0;
         armed_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         p1_q          <= p1_d;
         p2_q          <= p2_d;
         winner_q      <= winner_d;
         serve_dir_q   <= serve_dir_d;
         score_clr_q   <= score_clr_d;
         ball_run_q    <= ball_run_d;
         ball_center_q <= ball_center_d;
         paddle_en_q   <= paddle_en_d;
         game_over_q   <= game_over_d;
         start_prev_q  <= start_btn;
         pause_prev_q  <= pause_btn;
         armed_q       <= 1'b1;
      end
   end

   assign ball_run    = ball_run_q;
   assign ball_center = ball_center_q;
   assign serve_dir   = serve_dir_q;
   assign paddle_en   = paddle_en_q;
   assign score_clr   = score_clr_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;
   assign p1_pts      = p1_q;
   assign p2_pts      = p2_q;
   assign state       = state_q;

endmodule
